// File: rtl/zap_mem_bus_pkg.sv
// zap_mem_bus_pkg
//   Shared definitions for the memory-bus arbiter and the memory stage:
//   access-size codes, arbiter state/owner encodings, and the byte-lane,
//   write-data replication and alignment helpers.
package zap_mem_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;   // 2'd3 is treated as a word as well

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } bus_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } bus_owner_t;

    // Byte lanes touched by an access of the given size at addr[1:0].
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] sel;
        case (size)
            SZ_BYTE: sel = 4'b0001 << addr_lo;
            SZ_HALF: sel = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    // Low-aligned store data copied onto every lane so the slave can pick
    // whichever lanes sel enables.
    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] dat;
        case (size)
            SZ_BYTE: dat = {4{wdata[7:0]}};
            SZ_HALF: dat = {2{wdata[15:0]}};
            default: dat = wdata;
        endcase
        return dat;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/zap_mem_bus_timeout.sv
// zap_mem_bus_timeout
//   Loadable, clearable up-counter that saturates at LIMIT-1 and flags
//   expiry when it sits there.
//   Ports:
//     i_clk, i_reset_n   clock, asynchronous active-low reset
//     i_clear            synchronous clear to zero (highest priority)
//     i_load, i_load_val synchronous load
//     i_en               count enable
//     o_expired          count == LIMIT-1
module zap_mem_bus_timeout #(
    parameter int unsigned LIMIT = 255,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != LAST)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/zap_mem_bus_arbiter.sv
// zap_mem_bus_arbiter
//   Shares one Wishbone-style memory port between the instruction fetch
//   (I-side) and the data requester (D-side). One bus cycle at a time,
//   D-side priority with bounded I-side starvation, lane/data generation,
//   alignment check, and bus error / timeout reporting as faults.
//   Ports:
//     i_clk, i_reset_n                   clock, asynchronous active-low reset
//     i_d_req/wr/size/addr/wdata         D-side request and qualifiers
//     o_d_ack/rdata/fault, o_data_stall  D-side response and stall
//     i_i_req/addr                       I-side word-read request
//     o_i_ack/rdata/fault                I-side response
//     o_wb_*                             bus master outputs
//     i_wb_dat/ack/err                   bus slave response
module zap_mem_bus_arbiter
    import zap_mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned D_STREAK_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_d_req,
    input  logic        i_d_wr,
    input  logic [1:0]  i_d_size,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_ack,
    output logic [31:0] o_d_rdata,
    output logic        o_d_fault,
    output logic        o_data_stall,

    input  logic        i_i_req,
    input  logic [31:0] i_i_addr,
    output logic        o_i_ack,
    output logic [31:0] o_i_rdata,
    output logic        o_i_fault,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);

    localparam int unsigned TW = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned SW = (D_STREAK_MAX < 2) ? 1 : $clog2(D_STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);

    bus_state_t       r_state;
    bus_owner_t       r_owner;
    logic [SW-1:0]    r_streak;
    logic             r_wb_cyc;
    logic             r_wb_we;
    logic [3:0]       r_wb_sel;
    logic [31:0]      r_wb_adr;
    logic [31:0]      r_wb_dat;
    logic             r_d_ack;
    logic             r_i_ack;
    logic [31:0]      r_rdata;
    logic             r_fault;

    logic             w_grant_d;
    logic             w_grant_i;
    logic [1:0]       w_size;
    logic [31:0]      w_addr;
    logic             w_misaligned;
    logic [3:0]       w_sel;
    logic [31:0]      w_dat;
    logic             w_in_bus;
    logic             w_expired;
    logic             w_bus_done;
    logic             w_fault_resp;
    logic             w_timer_clear;

    // D wins unless I is waiting and D has already had its streak.
    assign w_grant_d = i_d_req & (~i_i_req | (r_streak < STREAK_MAX));
    assign w_grant_i = ~w_grant_d & i_i_req;

    // The I-side is always a word read.
    assign w_size       = w_grant_d ? i_d_size : SZ_WORD;
    assign w_addr       = w_grant_d ? i_d_addr : i_i_addr;
    assign w_misaligned = misaligned(w_size, w_addr[1:0]);
    assign w_sel        = lane_sel(w_size, w_addr[1:0]);
    assign w_dat        = w_grant_d ? replicate(w_size, i_d_wdata) : '0;

    assign w_in_bus      = (r_state == ST_BUS);
    assign w_bus_done    = w_in_bus & (i_wb_ack | i_wb_err | w_expired);
    // Only a clean ack with no error is a successful read; err wins over ack.
    assign w_fault_resp  = i_wb_err | ~i_wb_ack;
    assign w_timer_clear = ~w_in_bus | w_bus_done;

    zap_mem_bus_timeout #(
        .LIMIT (TIMEOUT),
        .WIDTH (TW)
    ) u_timeout (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_clear    (w_timer_clear),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_in_bus),
        .o_expired  (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= ST_IDLE;
            r_owner  <= OWN_I;
            r_streak <= '0;
            r_wb_cyc <= 1'b0;
            r_wb_we  <= 1'b0;
            r_wb_sel <= '0;
            r_wb_adr <= '0;
            r_wb_dat <= '0;
            r_d_ack  <= 1'b0;
            r_i_ack  <= 1'b0;
            r_rdata  <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_d_ack <= 1'b0;
            r_i_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d && i_i_req) begin
                        if (r_streak != STREAK_MAX) begin
                            r_streak <= r_streak + SW'(1);
                        end
                    end else begin
                        r_streak <= '0;
                    end

                    if (w_grant_d || w_grant_i) begin
                        r_owner <= w_grant_d ? OWN_D : OWN_I;
                        if (w_misaligned) begin
                            // No bus cycle: answer straight away with a fault.
                            r_state <= ST_RESP;
                            r_rdata <= '0;
                            r_fault <= 1'b1;
                            r_d_ack <= w_grant_d;
                            r_i_ack <= w_grant_i;
                        end else begin
                            r_state  <= ST_BUS;
                            r_wb_cyc <= 1'b1;
                            r_wb_we  <= w_grant_d & i_d_wr;
                            r_wb_sel <= w_sel;
                            r_wb_adr <= {w_addr[31:2], 2'b00};
                            r_wb_dat <= w_dat;
                        end
                    end
                end

                ST_BUS: begin
                    if (w_bus_done) begin
                        r_state  <= ST_RESP;
                        r_wb_cyc <= 1'b0;
                        r_d_ack  <= (r_owner == OWN_D);
                        r_i_ack  <= (r_owner == OWN_I);
                        r_fault  <= w_fault_resp;
                        r_rdata  <= w_fault_resp ? '0 : i_wb_dat;
                    end
                end

                ST_RESP: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_d_ack      = r_d_ack;
    assign o_d_rdata    = r_rdata;
    assign o_d_fault    = r_fault;
    assign o_data_stall = i_d_req & ~r_d_ack;

    assign o_i_ack      = r_i_ack;
    assign o_i_rdata    = r_rdata;
    assign o_i_fault    = r_fault;

    assign o_wb_cyc     = r_wb_cyc;
    assign o_wb_stb     = r_wb_cyc;
    assign o_wb_we      = r_wb_we;
    assign o_wb_sel     = r_wb_sel;
    assign o_wb_adr     = r_wb_adr;
    assign o_wb_dat     = r_wb_dat;

endmodule
